// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle Hack CPU control/datapath shell.
// Drives the external combinational Hack ALU, sequences instruction fetch
// and data memory accesses, and commits results to A, D and PC.
// Optional debug taps (A, D, state, retired count) under HACK_CPU_DEBUG_EN.
module hack_cpu_ctrl #(
  parameter int          PC_W     = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     instr_in,
  input  logic            instr_valid,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_re,
  output logic            mem_we,
  output logic [15:0]     mem_wdata,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_ack,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic            alu_zx,
  output logic            alu_nx,
  output logic            alu_zy,
  output logic            alu_ny,
  output logic            alu_f,
  output logic            alu_no,
  input  logic [15:0]     alu_out,
  input  logic            alu_zr,
  input  logic            alu_ng
`ifdef HACK_CPU_DEBUG_EN
  ,
  output logic [15:0]     dbg_a,
  output logic [15:0]     dbg_d,
  output logic [2:0]      dbg_state,
  output logic [31:0]     dbg_retired
`endif
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    READ_M  = 3'd2,
    EXEC    = 3'd3,
    WRITE_M = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     d_q, d_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     m_q, m_d;
  logic [15:0]     r_q, r_d;
  logic            zr_q, zr_d;
  logic            ng_q, ng_d;

  logic [PC_W-1:0] pc_inc;
  logic            jmp;

  assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  // Jump decision uses the flags captured in EXEC, not the live ALU flags.
  assign jmp    = (ir_q[2] & ng_q) | (ir_q[1] & zr_q) | (ir_q[0] & ~ng_q & ~zr_q);

  // Request strobes come straight from state, masked while reset is high.
  assign instr_req = (state_q == FETCH)   & ~reset;
  assign mem_re    = (state_q == READ_M)  & ~reset;
  assign mem_we    = (state_q == WRITE_M) & ~reset;

  assign pc        = pc_q;
  assign mem_addr  = a_q[PC_W-1:0];
  assign mem_wdata = r_q;

  assign alu_x  = d_q;
  assign alu_y  = ir_q[12] ? m_q : a_q;
  assign alu_zx = ir_q[11];
  assign alu_nx = ir_q[10];
  assign alu_zy = ir_q[9];
  assign alu_ny = ir_q[8];
  assign alu_f  = ir_q[7];
  assign alu_no = ir_q[6];

  // Next-state and datapath update for the instruction sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    ir_d    = ir_q;
    m_d     = m_q;
    r_d     = r_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!ir_q[15]) begin
          a_d     = {1'b0, ir_q[14:0]};
          pc_d    = pc_inc;
          state_d = FETCH;
        end else if (ir_q[12]) begin
          state_d = READ_M;
        end else begin
          state_d = EXEC;
        end
      end
      READ_M: begin
        if (mem_ack) begin
          m_d     = mem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        r_d     = alu_out;
        zr_d    = alu_zr;
        ng_d    = alu_ng;
        state_d = ir_q[3] ? WRITE_M : COMMIT;
      end
      WRITE_M: begin
        if (mem_ack) state_d = COMMIT;
      end
      COMMIT: begin
        if (ir_q[5]) a_d = r_q;
        if (ir_q[4]) d_d = r_q;
        // Target is the pre-commit A, even when dest includes A.
        pc_d    = jmp ? a_q[PC_W-1:0] : pc_inc;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Architectural and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= PC_W'(RESET_PC);
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      m_q     <= '0;
      r_q     <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ir_q    <= ir_d;
      m_q     <= m_d;
      r_q     <= r_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
    end
  end

`ifdef HACK_CPU_DEBUG_EN
  logic [31:0] retired_q, retired_d;

  assign retired_d = retired_q +
    32'(((state_q == DECODE) && !ir_q[15]) || (state_q == COMMIT));

  // Retired-instruction counter: A-instructions at DECODE, C-instructions at COMMIT.
  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign dbg_a       = a_q;
  assign dbg_d       = d_q;
  assign dbg_state   = state_q;
  assign dbg_retired = retired_q;
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl with a behavioural Hack ALU and a
// simple instruction/data responder driven from tasks.
module tb_hack_cpu_ctrl;

  localparam int PC_W = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic            instr_req;
  logic [PC_W-1:0] pc;
  logic [15:0]     instr_in;
  logic            instr_valid;
  logic [PC_W-1:0] mem_addr;
  logic            mem_re, mem_we;
  logic [15:0]     mem_wdata, mem_rdata;
  logic            mem_ack;
  logic [15:0]     alu_x, alu_y, alu_out;
  logic            alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic            alu_zr, alu_ng;
`ifdef HACK_CPU_DEBUG_EN
  logic [15:0]     dbg_a, dbg_d;
  logic [2:0]      dbg_state;
  logic [31:0]     dbg_retired;
`endif

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .pc(pc), .instr_in(instr_in), .instr_valid(instr_valid),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
`ifdef HACK_CPU_DEBUG_EN
    , .dbg_a(dbg_a), .dbg_d(dbg_d), .dbg_state(dbg_state), .dbg_retired(dbg_retired)
`endif
  );

  // Reference Hack ALU.
  logic [15:0] ax, ay, ao;
  always_comb begin
    ax = alu_zx ? 16'h0 : alu_x;
    ax = alu_nx ? ~ax : ax;
    ay = alu_zy ? 16'h0 : alu_y;
    ay = alu_ny ? ~ay : ay;
    ao = alu_f ? (ax + ay) : (ax & ay);
    ao = alu_no ? ~ao : ao;
  end
  assign alu_out = ao;
  assign alu_zr  = (ao == 16'h0);
  assign alu_ng  = ao[15];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Per-instruction observations.
  int          r_cyc, r_we;
  logic [14:0] r_waddr, r_raddr;
  logic [15:0] r_wdata, r_y;
  logic [5:0]  r_ctl;
  logic        r_stable;
  logic        onehot_bad = 1'b0;

  // Runs one instruction from FETCH back to FETCH; each memory request is
  // acked after `waits` stall cycles.
  task automatic run(input logic [15:0] instr, input logic [15:0] rdata, input int waits);
    int  wcnt;
    bit  done;
    wcnt = waits; done = 0;
    r_cyc = 0; r_we = 0; r_stable = 1'b1;
    r_waddr = '0; r_raddr = '0; r_wdata = '0; r_y = '0; r_ctl = '0;
    instr_in = instr; instr_valid = 1'b1; mem_rdata = rdata;
    for (int i = 0; i < 64 && !done; i++) begin
      if ($countones({instr_req, mem_re, mem_we}) > 1) onehot_bad = 1'b1;
      mem_ack = 1'b0;
      if (mem_re || mem_we) begin
        if (wcnt == 0) begin mem_ack = 1'b1; wcnt = waits; end
        else wcnt--;
      end
      if (mem_re) r_raddr = mem_addr;
      if (mem_we) begin
        if (r_we == 0) begin r_waddr = mem_addr; r_wdata = mem_wdata; end
        else if (mem_addr != r_waddr || mem_wdata != r_wdata) r_stable = 1'b0;
        r_we++;
      end
      tick;
      r_cyc++;
      mem_ack = 1'b0;
      if (r_cyc == 1) begin
        instr_valid = 1'b0;
        r_ctl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
        r_y   = alu_y;
      end
      if (instr_req) done = 1;
    end
    if (!done) chk("timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; instr_in = '0; instr_valid = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick; tick;
    chk("rst_req", instr_req, 0);
    chk("rst_we",  mem_we, 0);
    chk("rst_re",  mem_re, 0);
    chk("rst_pc",  pc, 0);
    chk("rst_a",   mem_addr, 0);
    chk("rst_d",   alu_x, 0);
    reset = 1'b0; #1;
    chk("first_req", instr_req, 1);

    // @5 then @7, D=A
    run(16'h0005, 0, 0);
    chk("a5_cyc", r_cyc, 2); chk("a5_a", mem_addr, 5); chk("a5_pc", pc, 1);
    run(16'h0007, 0, 0);     chk("a7_pc", pc, 2);
    run(16'hEC10, 0, 0);
    chk("dA_cyc", r_cyc, 4); chk("dA_ctl", r_ctl, 6'b110000); chk("dA_y", r_y, 7);
    chk("dA_d", alu_x, 7);   chk("dA_pc", pc, 3);

    // M=D+1 with three wait cycles
    run(16'h0064, 0, 0);     chk("a100_pc", pc, 4);
    run(16'hE7C8, 0, 3);
    chk("wm_cyc", r_cyc, 8);   chk("wm_we", r_we, 4);
    chk("wm_addr", r_waddr, 100); chk("wm_data", r_wdata, 8);
    chk("wm_stable", r_stable, 1); chk("wm_d", alu_x, 7); chk("wm_pc", pc, 5);

    // D;JGT with D=8, 0, 0xFFFF
    run(16'h0008, 0, 0); run(16'hEC10, 0, 0); run(16'h0028, 0, 0);
    run(16'hE301, 0, 0);     chk("jgt_pos", pc, 40);
    run(16'h0000, 0, 0); run(16'hEC10, 0, 0); run(16'h0028, 0, 0);
    run(16'hE301, 0, 0);     chk("jgt_zero", pc, 44);
    run(16'hEE90, 0, 0);     chk("dm1_d", alu_x, 16'hFFFF);
    run(16'h0028, 0, 0);
    run(16'hE301, 0, 0);     chk("jgt_neg", pc, 47);

    // AM=M-1 at A=10, then D=M with read waits
    run(16'h000A, 0, 0);
    run(16'hFCA8, 16'h1234, 0);
    chk("am_cyc", r_cyc, 6); chk("am_raddr", r_raddr, 10);
    chk("am_waddr", r_waddr, 10); chk("am_wdata", r_wdata, 16'h1233);
    chk("am_a", mem_addr, 15'h1233); chk("am_pc", pc, 49);
    run(16'hFC10, 16'h1234, 2);
    chk("dm_cyc", r_cyc, 7); chk("dm_d", alu_x, 16'h1234); chk("dm_pc", pc, 50);

    // A=D;JMP jumps to old A
    run(16'h0028, 0, 0);
    run(16'hE327, 0, 0);
    chk("adj_pc", pc, 40); chk("adj_a", mem_addr, 15'h1234);

    // PC wrap at 0x7FFF
    run(16'h7FFF, 0, 0);
    run(16'hEA87, 0, 0);     chk("jmp_7fff", pc, 15'h7FFF);
    run(16'h0005, 0, 0);     chk("pc_wrap", pc, 0);

    chk("onehot", onehot_bad, 0);

    // Reset while a write is stalled
    instr_in = 16'hE7C8; instr_valid = 1'b1;
    tick; instr_valid = 1'b0;
    tick; tick;
    chk("wr_pending", mem_we, 1);
    reset = 1'b1;
    tick;
    chk("rw_we", mem_we, 0); chk("rw_req", instr_req, 0);
    chk("rw_pc", pc, 0); chk("rw_a", mem_addr, 0); chk("rw_d", alu_x, 0);
    reset = 1'b0; #1;
    chk("rw_req_after", instr_req, 1);
    tick;
    chk("rw_hold_fetch", instr_req, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
